// File: rtl/fp_issue_pkg.sv
// Shared types and sizing helpers for the FP issue/retire controller.
//   fflags_t    : IEEE exception flags, packed NV (bit 4) down to NX (bit 0)
//   rob_entry_t : per-tag control state of a reorder-buffer entry
//   cnt_w()     : width of an occupancy counter able to hold 0..depth
package fp_issue_pkg;

  localparam int unsigned DEF_DEPTH  = 4;
  localparam int unsigned DEF_NREGS  = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_TAG_W  = $clog2(DEF_DEPTH);
  localparam int unsigned DEF_CNT_W  = $clog2(DEF_DEPTH + 1);
  localparam int unsigned NFLAGS     = 5;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  // rd and data live in parallel arrays in the top because their widths
  // follow the NREGS/DATA_W overrides of each instance.
  typedef struct packed {
    logic    valid;
    logic    done;
    logic    killed;
    logic    rd_fp;
    fflags_t status;
  } rob_entry_t;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// FP register scoreboard: one pending-write bit per FP register.
//   clk, rst_n          : clock, asynchronous active-low reset
//   set_en/set_addr     : mark a register as pending (issue)
//   clr_en/clr_addr     : release a register (retire)
//   clr_all             : release every register (flush), wins over set/clear
//   rs_addr/rs_used     : three packed source addresses and their use mask
//   rd_addr/rd_fp       : destination of the op under test
//   hazard              : RAW on any used source or WAW on an FP destination
module fp_scoreboard
  import fp_issue_pkg::*;
#(
  parameter  int unsigned NREGS = DEF_NREGS,
  localparam int unsigned REG_W = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               set_en,
  input  logic [REG_W-1:0]   set_addr,
  input  logic               clr_en,
  input  logic [REG_W-1:0]   clr_addr,
  input  logic               clr_all,
  input  logic [3*REG_W-1:0] rs_addr,
  input  logic [2:0]         rs_used,
  input  logic [REG_W-1:0]   rd_addr,
  input  logic               rd_fp,
  output logic               hazard
);

  logic [NREGS-1:0] sb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q <= '0;
    end else if (clr_all) begin
      sb_q <= '0;
    end else begin
      if (clr_en) sb_q[clr_addr] <= 1'b0;
      if (set_en) sb_q[set_addr] <= 1'b1;
    end
  end

  always_comb begin
    hazard = rd_fp && sb_q[rd_addr];
    for (int unsigned i = 0; i < 3; i++) begin
      if (rs_used[i] && sb_q[rs_addr[i*REG_W +: REG_W]]) hazard = 1'b1;
    end
  end

endmodule

// File: rtl/fp_issue_rob.sv
// FP issue/retire controller between the FP decoder and the FPU.
// Tags ops on issue, blocks RAW/WAW hazards via the scoreboard, reorders
// out-of-order FPU completions into in-order writeback and accumulates
// sticky fflags.
//   issue_*   : decoder handshake (valid/ready) and operand/dest addresses
//   fpu_in_*  : issue handshake to the FPU, fpu_tag_o carries the ROB tag
//   fpu_out_* : FPU completion (tag, result, status), always accepted
//   wb_*      : in-order writeback handshake to the register files
//   flush_i   : kill everything in flight; fflags_clr_i: clear sticky flags
//   fflags_o  : sticky flags; busy_o: any op in flight
module fp_issue_rob
  import fp_issue_pkg::*;
#(
  parameter  int unsigned DEPTH  = DEF_DEPTH,
  parameter  int unsigned NREGS  = DEF_NREGS,
  parameter  int unsigned DATA_W = DEF_DATA_W,
  localparam int unsigned TAG_W  = $clog2(DEPTH),
  localparam int unsigned REG_W  = $clog2(NREGS)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [3*REG_W-1:0] rs_addr_i,
  input  logic [2:0]         rs_used_i,
  input  logic [REG_W-1:0]   rd_addr_i,
  input  logic               rd_fp_i,
  output logic               fpu_in_valid_o,
  input  logic               fpu_in_ready_i,
  output logic [TAG_W-1:0]   fpu_tag_o,
  input  logic               fpu_out_valid_i,
  input  logic [TAG_W-1:0]   fpu_tag_i,
  input  logic [DATA_W-1:0]  fpu_result_i,
  input  logic [4:0]         fpu_status_i,
  output logic               wb_valid_o,
  input  logic               wb_ready_i,
  output logic [REG_W-1:0]   wb_rd_o,
  output logic               wb_fp_o,
  output logic [DATA_W-1:0]  wb_data_o,
  input  logic               flush_i,
  input  logic               fflags_clr_i,
  output logic [4:0]         fflags_o,
  output logic               busy_o
);

  localparam int unsigned      CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  rob_entry_t        rob_q  [DEPTH];
  logic [REG_W-1:0]  rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [TAG_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;
  fflags_t           fflags_q;

  rob_entry_t head_e;
  logic       hazard, full, fire, head_live, retire, wb_commit;
  logic       comp_hits_live;

  assign head_e    = rob_q[head_q];
  assign full      = (count_q == FULL);
  assign fire      = fpu_in_valid_o && fpu_in_ready_i;
  assign head_live = head_e.valid && head_e.done;
  // Killed heads drain silently; live heads wait for the writeback port.
  assign retire    = head_live && (head_e.killed || wb_ready_i);
  assign wb_commit = wb_valid_o && wb_ready_i;

  assign issue_ready_o  = !(full || hazard || !fpu_in_ready_i) && !flush_i;
  assign fpu_in_valid_o = issue_valid_i && !hazard && !full && !flush_i;
  assign fpu_tag_o      = tail_q;

  assign wb_valid_o = head_live && !head_e.killed;
  assign wb_rd_o    = rd_q[head_q];
  assign wb_fp_o    = head_e.rd_fp;
  assign wb_data_o  = data_q[head_q];
  assign fflags_o   = fflags_q;
  assign busy_o     = (count_q != '0);

  fp_scoreboard #(
    .NREGS (NREGS)
  ) u_sb (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .set_en   (fire && rd_fp_i),
    .set_addr (rd_addr_i),
    .clr_en   (wb_commit && head_e.rd_fp),
    .clr_addr (rd_q[head_q]),
    .clr_all  (flush_i),
    .rs_addr  (rs_addr_i),
    .rs_used  (rs_used_i),
    .rd_addr  (rd_addr_i),
    .rd_fp    (rd_fp_i),
    .hazard   (hazard)
  );

  // Issue never targets the head while it is occupied (that would need a
  // full ROB), so the per-entry priority below cannot drop a live retire.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rob_q[i]  <= '0;
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (fire && (TAG_W'(i) == tail_q)) begin
          rob_q[i].valid  <= 1'b1;
          rob_q[i].done   <= 1'b0;
          rob_q[i].killed <= 1'b0;
          rob_q[i].rd_fp  <= rd_fp_i;
          rob_q[i].status <= '0;
          rd_q[i]         <= rd_addr_i;
        end else if (retire && (TAG_W'(i) == head_q)) begin
          rob_q[i] <= '0;
        end else if (rob_q[i].valid) begin
          if (fpu_out_valid_i && (fpu_tag_i == TAG_W'(i))) begin
            rob_q[i].done   <= 1'b1;
            rob_q[i].status <= fflags_t'(fpu_status_i);
            data_q[i]       <= fpu_result_i;
          end
          if (flush_i) rob_q[i].killed <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      fflags_q <= '0;
    end else begin
      if (fire)   tail_q <= tail_q + TAG_W'(1);
      if (retire) head_q <= head_q + TAG_W'(1);
      count_q <= count_q + CNT_W'(fire) - CNT_W'(retire);
      if (fflags_clr_i)   fflags_q <= '0;
      else if (wb_commit) fflags_q <= fflags_t'(fflags_q | head_e.status);
    end
  end

  assign comp_hits_live = rob_q[fpu_tag_i].valid;

  a_completion_tag_live: assert property (
    @(posedge clk_i) disable iff (!rst_ni) fpu_out_valid_i |-> comp_hits_live
  );

endmodule

// File: tb/tb_fp_issue_rob.sv
module tb_fp_issue_rob;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [14:0] rs_addr_i;
  logic [2:0]  rs_used_i;
  logic [4:0]  rd_addr_i;
  logic        rd_fp_i;
  logic        fpu_in_valid_o;
  logic        fpu_in_ready_i;
  logic [1:0]  fpu_tag_o;
  logic        fpu_out_valid_i;
  logic [1:0]  fpu_tag_i;
  logic [31:0] fpu_result_i;
  logic [4:0]  fpu_status_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic        wb_fp_o;
  logic [31:0] wb_data_o;
  logic        flush_i;
  logic        fflags_clr_i;
  logic [4:0]  fflags_o;
  logic        busy_o;

  fp_issue_rob #(.DEPTH(DEPTH), .NREGS(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .rs_addr_i(rs_addr_i), .rs_used_i(rs_used_i),
    .rd_addr_i(rd_addr_i), .rd_fp_i(rd_fp_i),
    .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
    .fpu_tag_o(fpu_tag_o),
    .fpu_out_valid_i(fpu_out_valid_i), .fpu_tag_i(fpu_tag_i),
    .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_rd_o(wb_rd_o), .wb_fp_o(wb_fp_o), .wb_data_o(wb_data_o),
    .flush_i(flush_i), .fflags_clr_i(fflags_clr_i),
    .fflags_o(fflags_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int fire_cnt = 0;

  // Descriptor of the op the decoder is presenting: result/status/latency
  // are what the FPU stub will produce for it.
  logic [31:0] d_data;
  logic [4:0]  d_status;
  int          d_lat;

  typedef struct { int tag; int due; logic [31:0] data; logic [4:0] status; } pend_t;
  pend_t pend[$];

  typedef struct {
    int tag; logic [4:0] rd; logic rd_fp;
    logic [31:0] data; logic [4:0] status; bit done; bit killed;
  } op_t;
  op_t ops[$];        // reference: in-flight ops in program order
  int  next_tag = 0;
  logic [4:0] m_flags = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk_i) cyc++;

  // FPU stub: accepts issued ops and returns them after their latency.
  always @(negedge clk_i) begin
    if (!rst_ni) pend.delete();
    else if (fpu_in_valid_o && fpu_in_ready_i) begin
      pend.push_back('{tag: int'(fpu_tag_o), due: cyc + d_lat, data: d_data, status: d_status});
      fire_cnt++;
    end
  end

  always @(posedge clk_i) begin
    int best;
    #1;
    fpu_out_valid_i = 1'b0;
    best = -1;
    foreach (pend[k])
      if (pend[k].due <= cyc && (best < 0 || pend[k].due < pend[best].due)) best = k;
    if (best >= 0) begin
      fpu_out_valid_i = 1'b1;
      fpu_tag_i       = 2'(pend[best].tag);
      fpu_result_i    = pend[best].data;
      fpu_status_i    = pend[best].status;
      pend.delete(best);
    end
  end

  // Monitor / scoreboard: predicts every handshake from the reference list,
  // compares the DUT, then advances the reference across the coming edge.
  always @(negedge clk_i) begin : monitor
    bit haz, pv, pr, wbv, ret;
    if (!rst_ni) begin
      ops.delete();
      next_tag = 0;
      m_flags  = '0;
    end else begin
      haz = 0;
      foreach (ops[k]) begin
        if (!ops[k].killed && ops[k].rd_fp) begin
          if (rd_fp_i && ops[k].rd == rd_addr_i) haz = 1;
          for (int s = 0; s < 3; s++)
            if (rs_used_i[s] && rs_addr_i[s*5 +: 5] == ops[k].rd) haz = 1;
        end
      end
      pv  = issue_valid_i && !haz && (ops.size() < DEPTH) && !flush_i;
      pr  = !haz && (ops.size() < DEPTH) && fpu_in_ready_i && !flush_i;
      wbv = (ops.size() > 0) && ops[0].done && !ops[0].killed;

      chk("issue_ready", issue_ready_o, pr);
      chk("fpu_in_valid", fpu_in_valid_o, pv);
      if (pv) chk("fpu_tag", fpu_tag_o, next_tag);
      chk("wb_valid", wb_valid_o, wbv);
      if (wbv) begin
        chk("wb_rd", wb_rd_o, ops[0].rd);
        chk("wb_fp", wb_fp_o, ops[0].rd_fp);
        chk("wb_data", wb_data_o, ops[0].data);
      end
      chk("fflags", fflags_o, m_flags);
      chk("busy", busy_o, ops.size() != 0);

      ret = (ops.size() > 0) && ops[0].done && (ops[0].killed || wb_ready_i);
      if (fflags_clr_i) m_flags = '0;
      else if (ret && !ops[0].killed) m_flags = m_flags | ops[0].status;
      if (fpu_out_valid_i)
        foreach (ops[k]) if (ops[k].tag == int'(fpu_tag_i)) ops[k].done = 1;
      if (ret) void'(ops.pop_front());
      if (flush_i) foreach (ops[k]) ops[k].killed = 1;
      if (pv && fpu_in_ready_i) begin
        ops.push_back('{tag: next_tag, rd: rd_addr_i, rd_fp: rd_fp_i,
                        data: d_data, status: d_status, done: 0, killed: 0});
        next_tag = (next_tag + 1) % DEPTH;
      end
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue_op(input logic [14:0] rs, input logic [2:0] used, input logic [4:0] rd,
                          input logic fp, input logic [4:0] st, input int lat);
    int start;
    start = fire_cnt;
    rs_addr_i = rs; rs_used_i = used; rd_addr_i = rd; rd_fp_i = fp;
    d_data = $urandom; d_status = st; d_lat = lat;
    issue_valid_i = 1'b1;
    for (int i = 0; i < 100 && fire_cnt == start; i++) tick();
    issue_valid_i = 1'b0;
    chk("issue_accept", 64'(fire_cnt - start), 64'd1);
  endtask

  task automatic wait_idle(input int n);
    for (int i = 0; i < n && busy_o; i++) tick();
    chk("drain_idle", busy_o, 1'b0);
  endtask

  initial begin
    rst_ni = 1'b0;
    issue_valid_i = 0; rs_addr_i = '0; rs_used_i = '0; rd_addr_i = '0; rd_fp_i = 0;
    fpu_in_ready_i = 1; fpu_out_valid_i = 0; fpu_tag_i = '0; fpu_result_i = '0;
    fpu_status_i = '0; wb_ready_i = 1; flush_i = 0; fflags_clr_i = 0;
    d_data = '0; d_status = '0; d_lat = 1;
    tick(); tick();
    chk("rst_in_valid", fpu_in_valid_o, 1'b0);
    chk("rst_issue_ready", issue_ready_o, 1'b1);
    chk("rst_wb_valid", wb_valid_o, 1'b0);
    chk("rst_fflags", fflags_o, 5'd0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_tag", fpu_tag_o, 2'd0);
    chk("rst_wb_data", wb_data_o, 32'd0);
    rst_ni = 1'b1;
    tick();

    // single op, NX
    issue_op(15'd0, 3'b000, 5'd3, 1'b1, 5'b00001, 3);
    wait_idle(50);
    chk("t1_fflags", fflags_o, 5'b00001);

    // four in flight, out-of-order return, fifth stalls on full
    issue_op(15'd0, 3'b000, 5'd10, 1'b1, 5'd0, 5);
    issue_op(15'd0, 3'b000, 5'd11, 1'b1, 5'd0, 10);
    issue_op(15'd0, 3'b000, 5'd12, 1'b1, 5'd0, 2);
    issue_op(15'd0, 3'b000, 5'd13, 1'b1, 5'd0, 4);
    issue_op(15'd0, 3'b000, 5'd14, 1'b1, 5'd0, 1);
    wait_idle(100);

    // RAW on f5
    issue_op(15'd0, 3'b000, 5'd5, 1'b1, 5'd0, 5);
    issue_op({10'd0, 5'd5}, 3'b001, 5'd6, 1'b1, 5'd0, 1);
    wait_idle(50);

    // flush with three in flight, then a fresh op
    fflags_clr_i = 1; tick(); fflags_clr_i = 0;
    issue_op(15'd0, 3'b000, 5'd20, 1'b1, 5'b10000, 8);
    issue_op(15'd0, 3'b000, 5'd21, 1'b1, 5'b10000, 8);
    issue_op(15'd0, 3'b000, 5'd22, 1'b0, 5'b10000, 8);
    flush_i = 1; tick(); flush_i = 0;
    issue_op(15'd0, 3'b000, 5'd20, 1'b1, 5'd0, 1);
    wait_idle(100);
    chk("t4_fflags", fflags_o, 5'd0);

    // writeback backpressure
    wb_ready_i = 0;
    issue_op(15'd0, 3'b000, 5'd8, 1'b1, 5'b10000, 2);
    for (int i = 0; i < 8; i++) tick();
    wb_ready_i = 1;
    wait_idle(50);

    // clear coincides with an OF retire
    wb_ready_i = 0;
    issue_op(15'd0, 3'b000, 5'd7, 1'b1, 5'b00100, 2);
    for (int i = 0; i < 50 && !wb_valid_o; i++) tick();
    chk("t6_wb_valid", wb_valid_o, 1'b1);
    wb_ready_i = 1; fflags_clr_i = 1; tick(); fflags_clr_i = 0;
    chk("t6_cleared", fflags_o, 5'd0);
    issue_op(15'd0, 3'b000, 5'd9, 1'b1, 5'b01000, 2);
    wait_idle(50);
    chk("t6_dz", fflags_o, 5'b01000);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      issue_valid_i  = ($urandom_range(0, 9) < 7);
      rs_addr_i      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rs_used_i      = 3'($urandom);
      rd_addr_i      = 5'($urandom_range(0, 7));
      rd_fp_i        = ($urandom_range(0, 3) != 0);
      d_data         = $urandom;
      d_status       = 5'($urandom);
      d_lat          = $urandom_range(1, 6);
      fpu_in_ready_i = ($urandom_range(0, 9) != 0);
      wb_ready_i     = ($urandom_range(0, 3) != 0);
      flush_i        = ($urandom_range(0, 49) == 0);
      fflags_clr_i   = ($urandom_range(0, 29) == 0);
      tick();
    end
    issue_valid_i = 0; flush_i = 0; fflags_clr_i = 0; wb_ready_i = 1; fpu_in_ready_i = 1;
    wait_idle(200);

    // asynchronous reset with ops in flight
    issue_op(15'd0, 3'b000, 5'd1, 1'b1, 5'b00010, 30);
    issue_op(15'd0, 3'b000, 5'd2, 1'b1, 5'b00010, 30);
    tick();
    rst_ni = 1'b0;
    #1;
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_wb_valid", wb_valid_o, 1'b0);
    chk("arst_tag", fpu_tag_o, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
